ddr_avalon_responder: RTL

- Services the camera-side write channel and display-side read channel (req/ready/addr/data/valid) on the DDR side.
- Converts accepted requests into single-word Avalon-MM master transactions toward the HPS SDRAM port.
- Returns read data in order with a valid strobe.
- Sits between the video pipeline and the fabric-to-SDRAM bridge in one clock domain; upstream FIFOs handle clock crossing.

---
 rtl/ddr_avalon_responder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ddr_avalon_responder.sv
// Arbitrates the camera write and display read channels onto single-word Avalon-MM commands.
// Optional statistics outputs are enabled by defining DDR_RESPONDER_STATS_EN.
module ddr_avalon_responder #(
  parameter int unsigned ADDR_SHIFT      = 2,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned WR_STARVE_LIMIT = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] DDR_WRITE_ADDR,
  input  logic [31:0] DDR_WRITE_DATA,
  input  logic        DDR_WRITE_REQ,
  output logic        DDR_WRITE_READY,
  input  logic [31:0] DDR_READ_ADDR,
  input  logic        DDR_READ_REQ,
  output logic        DDR_READ_READY,
  output logic [31:0] DDR_READ_DATA,
  output logic        DDR_READ_DATA_VALID,
  output logic [31:0] avm_address,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
`ifdef DDR_RESPONDER_STATS_EN
  ,
  output logic [31:0] stat_wr_cnt,
  output logic [31:0] stat_rd_cnt,
  output logic [31:0] stat_stall_cnt
`endif
);

  localparam int unsigned SW = $clog2(WR_STARVE_LIMIT + 1);

  typedef enum logic [1:0] {SLOT_EMPTY, SLOT_WR_PEND, SLOT_RD_PEND} slot_t;

  slot_t         slot;
  logic [3:0]    outstanding;
  logic [4:0]    outstanding_next;
  logic [SW-1:0] starve;
  logic          slot_free;
  logic          rd_issue;
  logic          rd_return;
  logic          rd_ok;
  logic          starved;
  logic          wr_ready;
  logic          rd_ready;

  assign avm_byteenable  = 4'hF;
  assign DDR_WRITE_READY = wr_ready;
  assign DDR_READ_READY  = rd_ready;

  // Ready is masked by reset so both channels stay quiet while reset is held.
  always_comb begin
    slot_free        = (slot == SLOT_EMPTY) || !avm_waitrequest;
    rd_issue         = (slot == SLOT_RD_PEND) && !avm_waitrequest;
    rd_return        = avm_readdatavalid && (outstanding != '0);
    outstanding_next = {1'b0, outstanding} + {4'b0, rd_issue};
    rd_ok            = DDR_READ_REQ && (outstanding_next < 5'(MAX_OUTSTANDING));
    starved          = DDR_WRITE_REQ && (starve == SW'(WR_STARVE_LIMIT));
    rd_ready         = sys_rst_n && slot_free && rd_ok && !starved;
    wr_ready         = sys_rst_n && slot_free && DDR_WRITE_REQ && !rd_ready;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      slot          <= SLOT_EMPTY;
      avm_write     <= 1'b0;
      avm_read      <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
    end else if (slot_free) begin
      if (wr_ready) begin
        slot          <= SLOT_WR_PEND;
        avm_write     <= 1'b1;
        avm_read      <= 1'b0;
        avm_address   <= DDR_WRITE_ADDR << ADDR_SHIFT;
        avm_writedata <= DDR_WRITE_DATA;
      end else if (rd_ready) begin
        slot        <= SLOT_RD_PEND;
        avm_write   <= 1'b0;
        avm_read    <= 1'b1;
        avm_address <= DDR_READ_ADDR << ADDR_SHIFT;
      end else begin
        slot      <= SLOT_EMPTY;
        avm_write <= 1'b0;
        avm_read  <= 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      outstanding <= '0;
    end else begin
      case ({rd_issue, rd_return})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      starve <= '0;
    end else if (!DDR_WRITE_REQ || wr_ready) begin
      starve <= '0;
    end else if (starve != SW'(WR_STARVE_LIMIT)) begin
      starve <= starve + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      DDR_READ_DATA       <= '0;
      DDR_READ_DATA_VALID <= 1'b0;
    end else begin
      DDR_READ_DATA_VALID <= rd_return;
      if (rd_return) DDR_READ_DATA <= avm_readdata;
    end
  end

`ifdef DDR_RESPONDER_STATS_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stat_wr_cnt    <= '0;
      stat_rd_cnt    <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (wr_ready) stat_wr_cnt <= stat_wr_cnt + 32'd1;
      if (rd_ready) stat_rd_cnt <= stat_rd_cnt + 32'd1;
      if ((slot != SLOT_EMPTY) && avm_waitrequest) stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
